regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback requesters: req0 = ALU result,
//  req1 = load data. Round-robin arbitration, one registered commit stage driving the write port,
//  RAW hazard flags for the decode read addresses, and per-requester saturating commit counters.
//  Sits between the execute/memory stages and the register file. Owns regWrite/write_reg/write_data.
// PARAMETERS
//  DATA_W   32   width of write data
//  ADDR_W   5    register address width (2**ADDR_W registers)
//  CNT_W    16   width of each commit counter
// PORTS
//  clk         in   1       single clock, all state updates on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req0_valid  in   1       ALU writeback request
//  req0_addr   in   ADDR_W  ALU destination register
//  req0_data   in   DATA_W  ALU result
//  req0_ready  out  1       ALU request accepted this cycle
//  req1_valid  in   1       load writeback request
//  req1_addr   in   ADDR_W  load destination register
//  req1_data   in   DATA_W  load data
//  req1_ready  out  1       load request accepted this cycle
//  rd_addr_a   in   ADDR_W  decode read address, port A
//  rd_addr_b   in   ADDR_W  decode read address, port B
//  hazard_a    out  1       write to rd_addr_a pending (requested or in commit stage)
//  hazard_b    out  1       write to rd_addr_b pending
//  rf_we       out  1       register-file write enable (regWrite)
//  rf_waddr    out  ADDR_W  register-file write address
//  rf_wdata    out  DATA_W  register-file write data
//  cnt0, cnt1  out  CNT_W   committed-write counts, req0 / req1
// BEHAVIOUR
//  Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, cnt0=cnt1=0, rr_ptr=0 (req0 favoured).
//   Ready/hazard outputs combinational; with rst_n=0 readies forced 0.
//  Arbitration (combinational, one grant per cycle):
//   - only one valid -> that requester gets ready=1.
//   - both valid -> requester named by rr_ptr gets ready=1; the other ready=0 and must hold
//     valid/addr/data stable until accepted.
//   - on each accept rr_ptr moves to the non-winner; no accept -> rr_ptr unchanged.
//   - neither valid -> both ready=0.
//  Commit stage: accept at edge N -> rf_we=1 with that addr/data for cycle N+1 (latency 1).
//   No accept -> rf_we=0 next cycle; rf_waddr/rf_wdata hold last values.
//  Register 0: accept of addr 0 is handshaken normally, but rf_we stays 0 next cycle
//   (write dropped); does not count in cnt0/cnt1; never flags a hazard.
//  Counters: increment on accept of nonzero addr; saturate at 2**CNT_W-1, no wrap.
//  Hazard: hazard_x=1 when rd_addr_x!=0 and equals (a) addr of a valid req0 or req1, granted or
//   not, or (b) rf_waddr while rf_we=1. Pure combinational; no forwarding in this block.
//  Same address on both requesters in one cycle: serialised by round-robin; the later grant's
//   data is the final register value.
//  Back-to-back: a requester may hold valid continuously; with both valid, grants alternate
//   0,1,0,1... -> no starvation; max wait is 1 cycle.
//  Reset mid-operation: commit stage cleared, a pending rf_we is dropped; requesters re-present.
// TESTING
//  1 Reset: rst_n=0 mid-write -> rf_we=0, cnt0=cnt1=0 immediately, without a clock edge.
//  2 Single: req0 addr=5 data=0xDEADBEEF for one cycle -> req0_ready=1; next cycle rf_we=1,
//    rf_waddr=5, rf_wdata=0xDEADBEEF; cnt0=1.
//  3 Contention: both valid 4 cycles after reset (req0 addr=3, req1 addr=7) -> grants 0,1,0,1;
//    rf_waddr sequence 3,7,3,7; cnt0=2, cnt1=2.
//  4 Reg0: req1 addr=0 data=0x1234 -> req1_ready=1, rf_we stays 0, cnt1 unchanged,
//    rd_addr_a=0 -> hazard_a=0.
//  5 Hazard: req1 valid addr=9 (losing arbitration), rd_addr_b=9 -> hazard_b=1 until the cycle
//    after rf_we for addr 9 deasserts.
//  6 Saturation: CNT_W=4, 17 req0 writes to addr 1 -> cnt0=15 and holds.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port
//
// Purpose: arbitrates ALU (req0) and load (req1) writebacks onto the single
// register-file write port through one registered commit stage, flags RAW
// hazards for the two decode read addresses, and counts committed writes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/addr/data/ready ALU writeback request and its acceptance
//   req1_valid/addr/data/ready load writeback request and its acceptance
//   rd_addr_a, rd_addr_b       decode read addresses
//   hazard_a, hazard_b         pending write to the matching read address
//   rf_we, rf_waddr, rf_wdata  register-file write port (commit stage)
//   cnt0, cnt1                 saturating committed-write counters
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // rr_ptr: 0 favours req0 on contention, 1 favours req1
  logic              rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              grant0, grant1;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grants are suppressed while reset is asserted so no handshake completes
  // against a commit stage that is being cleared.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr_q;
        grant1 = rr_ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    sel_addr   = grant1 ? req1_addr : req0_addr;
    sel_data   = grant1 ? req1_data : req0_data;

    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    // Pointer moves to whichever requester did not win this cycle.
    if (grant0) begin
      rr_ptr_d = 1'b1;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
    end

    // Register 0 is hardwired: its writes are handshaken but silently dropped,
    // leaving the write port address/data untouched.
    if (accept && (sel_addr != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end

    if (grant0 && (req0_addr != '0) && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_ONE;
    end
    if (grant1 && (req1_addr != '0) && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  // A read address is hazarded by any visible request (granted or waiting)
  // or by the write sitting in the commit stage. Nothing is forwarded here.
  assign hazard_a = (rd_addr_a != '0) &&
                    ((req0_valid && (req0_addr == rd_addr_a)) ||
                     (req1_valid && (req1_addr == rd_addr_a)) ||
                     (rf_we_q && (rf_waddr_q == rd_addr_a)));

  assign hazard_b = (rd_addr_b != '0) &&
                    ((req0_valid && (req0_addr == rd_addr_b)) ||
                     (req1_valid && (req1_addr == rd_addr_b)) ||
                     (rf_we_q && (rf_waddr_q == rd_addr_b)));

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        hazard_a, hazard_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cnt0(cnt0), .cnt1(cnt1)
  );

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        er0;
    logic        er1;
    logic        eha;
    logic        ehb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [CNT_W-1:0] c0;
    logic [CNT_W-1:0] c1;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [CNT_W-1:0] m_cnt0, m_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic er0, input logic er1, input logic eha, input logic ehb);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.ra = ra; v.rb = rb;
    v.er0 = er0; v.er1 = er1; v.eha = eha; v.ehb = ehb;
    return v;
  endfunction

  task automatic model_reset();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt0 = '0; m_cnt1 = '0;
  endtask

  // Called at posedge+1: drive, check combinational outputs, predict the
  // commit stage from the expected grants, then compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    rd_addr_a  = v.ra; rd_addr_b = v.rb;
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(v.er0));
    chk("req1_ready", 32'(req1_ready), 32'(v.er1));
    chk("hazard_a",   32'(hazard_a),   32'(v.eha));
    chk("hazard_b",   32'(hazard_b),   32'(v.ehb));
    m_we = 1'b0;
    if (v.er0 && v.a0 != 5'd0) begin
      m_we = 1'b1; m_waddr = v.a0; m_wdata = v.d0;
      if (m_cnt0 != CMAX) m_cnt0 = m_cnt0 + 4'd1;
    end
    if (v.er1 && v.a1 != 5'd0) begin
      m_we = 1'b1; m_waddr = v.a1; m_wdata = v.d1;
      if (m_cnt1 != CMAX) m_cnt1 = m_cnt1 + 4'd1;
    end
    e.we = m_we; e.waddr = m_waddr; e.wdata = m_wdata; e.c0 = m_cnt0; e.c1 = m_cnt1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("rf_we", 32'(rf_we), 32'(got.we));
    if (got.we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(got.waddr));
      chk("rf_wdata", rf_wdata, got.wdata);
    end
    chk("cnt0", 32'(cnt0), 32'(got.c0));
    chk("cnt1", 32'(cnt1), 32'(got.c1));
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[9];
  vec_t idle;

  initial begin
    // single write, register 0 drop, then hazard on a losing load request
    tbl[0] = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[2] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd9, 32'hBBBB0009, 5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[5] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hBBBB0009, 5'd4, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[6] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd4, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[7] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd4, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(1'b1, 5'd2, 32'h00000055, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle   = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_rf_we",    32'(rf_we),    32'd0);
    chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset_rf_wdata", rf_wdata,      32'd0);
    chk("reset_cnt0",     32'(cnt0),     32'd0);
    chk("reset_cnt1",     32'(cnt1),     32'd0);
    do_reset();

    for (int i = 0; i < 9; i++) apply(tbl[i]);

    // asynchronous reset in the middle of a committed write
    chk("pre_reset_rf_we", 32'(rf_we), 32'd1);
    req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66;
    rst_n = 1'b0;
    #1;
    chk("async_rf_we",   32'(rf_we),      32'd0);
    chk("async_cnt0",    32'(cnt0),       32'd0);
    chk("async_cnt1",    32'(cnt1),       32'd0);
    chk("async_ready0",  32'(req0_ready), 32'd0);
    do_reset();

    // contention: grants alternate 0,1,0,1 from the reset pointer
    for (int i = 0; i < 4; i++) begin
      apply(mk(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd7, 32'h77777777, 5'd3, 5'd7,
               (i % 2 == 0), (i % 2 == 1), 1'b1, 1'b1));
    end
    chk("contention_cnt0", 32'(cnt0), 32'd2);
    chk("contention_cnt1", 32'(cnt1), 32'd2);
    apply(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(idle);

    // saturation: 17 writes to a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply(mk(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    chk("sat_cnt0", 32'(cnt0), 32'd15);
    apply(idle);
    chk("sat_hold_cnt0", 32'(cnt0), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
